// File: rtl/i2c_resp_pkg.sv
// Shared types and bus constants for the I2C target responder.
package i2c_resp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK_CHK,
        ST_IGNORE
    } i2c_resp_state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// Synchronises and filters raw SCL/SDA, then produces one-cycle pulses for
// SCL edges and START/STOP conditions seen on the filtered levels.
module i2c_bus_cond_detect #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_flt, sda_flt, scl_prev, sda_prev;
    logic [CW-1:0] scl_cnt, sda_cnt;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

    // Run filter: the filtered level only follows after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_flt <= 1'b1;
            sda_flt <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_flt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
                scl_flt <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + CW'(1);
            end
            if (sda_sync[1] == sda_flt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
                sda_flt <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + CW'(1);
            end
        end
    end

    // Previous filtered levels for edge and condition detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_flt;
            sda_prev <= sda_flt;
        end
    end

    assign sda_level = sda_flt;
    assign scl_rise  = scl_flt & ~scl_prev;
    assign scl_fall  = ~scl_flt & scl_prev;
    // SDA may only move while SCL is low, so any SDA edge with SCL steadily high is a condition.
    assign start     = scl_flt & scl_prev & sda_prev & ~sda_flt;
    assign stop      = scl_flt & scl_prev & ~sda_prev & sda_flt;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a small byte register file: first written byte sets the
// pointer, later bytes are stored at it; reads stream from the pointer.
// Both directions auto-increment the pointer with wrap-around.
module i2c_slave_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h22,
    parameter int         MEM_AW     = 4,
    parameter int         FILTER_LEN = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    input  logic              host_we_i,
    input  logic [MEM_AW-1:0] host_addr_i,
    input  logic [7:0]        host_wdata_i,
    output logic              wr_strobe_o,
    output logic [MEM_AW-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o,
    output logic              nack_o,
    output i2c_resp_state_t   state_o
);

    localparam int MEM_SIZE = 1 << MEM_AW;

    logic              sda_level, scl_rise, scl_fall, bus_start, bus_stop;
    i2c_resp_state_t   state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        rx_byte;
    logic [MEM_AW-1:0] ptr, ptr_nxt;
    logic              rw;
    logic [7:0]        mem [MEM_SIZE];

    i2c_bus_cond_detect #(.FILTER_LEN(FILTER_LEN)) u_cond (
        .clk       (clk_i),
        .rst       (rst_i),
        .scl       (scl_i),
        .sda       (sda_i),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (bus_start),
        .stop      (bus_stop)
    );

    assign rx_byte = {shreg[6:0], sda_level};
    assign ptr_nxt = ptr + MEM_AW'(1);
    assign state_o = state;

    // Protocol FSM plus register file; the I2C write is placed after the host write so it wins a collision.
    // In the ACK states sda_o itself marks the phase: released = ACK not yet driven.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            rw          <= I2C_WRITE;
            sda_o       <= 1'b1;
            busy_o      <= 1'b0;
            nack_o      <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
        end else begin
            wr_strobe_o <= 1'b0;
            nack_o      <= 1'b0;
            if (host_we_i) mem[host_addr_i] <= host_wdata_i;
            if (bus_start) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_o   <= 1'b1;
            end else if (bus_stop) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
                sda_o  <= 1'b1;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state  <= ST_ADDR_ACK;
                                busy_o <= 1'b1;
                                rw     <= rx_byte[0];
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (sda_o) begin
                            sda_o <= I2C_ACK;
                        end else if (rw == I2C_READ) begin
                            shreg   <= mem[ptr];
                            sda_o   <= mem[ptr][7];
                            bit_cnt <= '0;
                            state   <= ST_RDATA;
                        end else begin
                            sda_o   <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_PTR;
                        end
                    end
                    ST_PTR, ST_WDATA: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (state == ST_PTR) begin
                                ptr   <= rx_byte[MEM_AW-1:0];
                                state <= ST_PTR_ACK;
                            end else begin
                                state <= ST_WDATA_ACK;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_PTR_ACK: if (scl_fall) begin
                        if (sda_o) begin
                            sda_o <= I2C_ACK;
                        end else begin
                            sda_o <= 1'b1;
                            state <= ST_WDATA;
                        end
                    end
                    ST_WDATA_ACK: if (scl_fall) begin
                        if (sda_o) begin
                            sda_o       <= I2C_ACK;
                            mem[ptr]    <= shreg;
                            wr_strobe_o <= 1'b1;
                            wr_addr_o   <= ptr;
                            wr_data_o   <= shreg;
                            ptr         <= ptr_nxt;
                        end else begin
                            sda_o <= 1'b1;
                            state <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_o <= 1'b1;
                                state <= ST_RACK_CHK;
                            end else if (bit_cnt == 4'd0) begin
                                sda_o <= shreg[7];
                            end else begin
                                sda_o <= shreg[6];
                                shreg <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RACK_CHK: if (scl_rise) begin
                        if (sda_level == I2C_ACK) begin
                            ptr     <= ptr_nxt;
                            shreg   <= mem[ptr_nxt];
                            bit_cnt <= '0;
                            state   <= ST_RDATA;
                        end else begin
                            nack_o <= 1'b1;
                            state  <= ST_IGNORE;
                        end
                    end
                    ST_IGNORE: sda_o <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
